cmp_scheduler: RTL and testbench
================================

Name: cmp_scheduler

Overview:
- Shares one clocked comparator unit (4-bit A/B operands, 2-bit mode C, enable EN, outputs Out_Bits/Out_C) among NREQ requesters.
- Arbitrates round-robin, latches the winner's operands, and drives the comparator's A/B/C/EN.
- Waits the comparator's pipeline latency, captures its result, and returns it to the winner with a one-cycle DONE pulse.
- Sits between the requesting blocks and the comparator datapath; it is the only driver of the comparator inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width; matches comparator A/B/Out_Bits.
- LAT, 1, comparator clocked latency in cycles from EN-qualified inputs to valid outputs (>=1).

Ports:
- CLK  in  1  rising-edge clock, shared with comparator.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester request level.
- REQ_A  in  NREQ*WIDTH  operand A; slice i belongs to requester i.
- REQ_B  in  NREQ*WIDTH  operand B; slice i belongs to requester i.
- REQ_C  in  NREQ*2  mode; slice i belongs to requester i.
- GNT  out  NREQ  one-hot grant, high from ISSUE through DONE.
- DONE  out  NREQ  one-hot, one-cycle result-valid pulse.
- RES_BITS  out  WIDTH  captured Out_Bits of the last completed operation.
- RES_C  out  1  captured Out_C of the last completed operation.
- BUSY  out  1  high in any state other than IDLE.
- CMP_A  out  WIDTH  to comparator A.
- CMP_B  out  WIDTH  to comparator B.
- CMP_C  out  2  to comparator C.
- CMP_EN  out  1  to comparator EN.
- CMP_OUT_BITS  in  WIDTH  from comparator Out_Bits.
- CMP_OUT_C  in  1  from comparator Out_C.

Behaviour:
- Reset (async, RST_N=0):
  - State IDLE; GNT=0, DONE=0, BUSY=0, CMP_EN=0.
  - CMP_A/B/C=0, RES_BITS=0, RES_C=0, RR pointer=0, wait counter=0.
  - Takes effect immediately, mid-operation included; an in-flight op is discarded with no DONE. Requesters must re-request.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If REQ!=0, pick the winner: first set bit at or after the RR pointer, scanning upward with wrap NREQ-1 -> 0.
  - Next edge: latch winner index, CMP_A/B/C <= winner's slices, GNT[winner]=1, CMP_EN=1, go to ISSUE.
  - If REQ==0, stay in IDLE.
- ISSUE: lasts 1 cycle; load wait counter with LAT-1; go to WAIT.
- WAIT:
  - CMP_EN stays 1 and CMP_A/B/C stay stable.
  - Counter decrements each cycle. When it reaches 0, the same edge captures CMP_OUT_BITS/CMP_OUT_C into RES_BITS/RES_C, drops CMP_EN, sets DONE[winner]=1, and goes to DONE.
- DONE:
  - Lasts 1 cycle; DONE and GNT are high; RES holds its value until the next capture.
  - Next edge: DONE=0, GNT=0, RR pointer <= (winner+1) mod NREQ, go to IDLE.
- Latency: REQ seen in IDLE at cycle 0 gives DONE high in cycle 2+LAT. Back-to-back throughput is one op per 3+LAT cycles.
- Handshake rules:
  - A requester holds REQ and its operands until it samples DONE, then drops REQ at that same edge. IDLE therefore never re-grants a just-served request.
  - Operands are latched at grant. Operand changes after grant are ignored.
  - REQ dropped mid-operation: the op still completes and DONE still pulses.
- Fairness: with all REQ held high, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 operations.
- Simultaneous events: new REQ arriving during ISSUE/WAIT/DONE is only considered on return to IDLE. Pointer update and new arbitration never occur in the same cycle.
- Mode C passes through unmodified, including 2'b11; its semantics belong to the comparator.
- CMP_EN=0 in IDLE and DONE. The comparator holds its outputs; they are ignored.

Decomposition:
- Package cmp_sched_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_WAIT=2'd2, ST_DONE=2'd3;
  - mode constants MODE_0..MODE_3 (2'b00..2'b11);
  - default NREQ/WIDTH/LAT.
- One sub-module: rr_arbiter. It is combinational: REQ plus pointer in, one-hot grant and encoded index out, plus an any-request flag. It is unit-testable on its own.
- FSM, operand mux/latch, counter and result capture stay in cmp_scheduler.

Test Plan:
Bench uses a stub comparator with LAT=1 and registered outputs Out_Bits=A^B, Out_C=(A>B) when EN=1, holding otherwise.
1. Reset, then REQ=0001 with requester 0 A=0011, B=0010, C=00 -> GNT=0001 from cycle 1; DONE=0001 in cycle 3 only; RES_BITS=0001, RES_C=1; CMP_EN high in cycles 1-2 only.
2. REQ=1111 held continuously, each requester re-asserting after its DONE -> grant order 0,1,2,3,0; exactly one DONE per 4 cycles; GNT always one-hot.
3. Requester 2 A=0111, B=0111, C=10 granted; its A changes to 1111 during WAIT -> CMP_A stays 0111; RES_BITS=0000, RES_C=0.
4. RST_N pulsed low during WAIT -> same-cycle GNT=0, CMP_EN=0, BUSY=0, RES=0; no DONE emitted; after release, a fresh REQ=0100 is granted with pointer starting at 0.
5. Requester 1 drops REQ during WAIT -> DONE=0010 still pulses with the correct result; pointer advances to 2.
6. REQ=1000 and REQ=0001 arrive together with pointer=3 -> requester 3 is granted first, requester 0 next; requester 0's DONE comes 4 cycles after requester 3's.

Source files
------------

// File: rtl/cmp_sched_pkg.sv
// Shared types and defaults for the comparator scheduler.
package cmp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned LAT_DEF   = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [IW-1:0]   idx_c,
  output logic            any_c
);

  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = IW'((32'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        gnt_c[j] = 1'b1;
        idx_c    = j;
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/cmp_scheduler.sv
// Round-robin scheduler sharing one clocked comparator among NREQ requesters.
module cmp_scheduler
  import cmp_sched_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_c,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      res_bits,
  output logic                  res_c,
  output logic                  busy,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  output logic [1:0]            cmp_c,
  output logic                  cmp_en,
  input  logic [WIDTH-1:0]      cmp_out_bits,
  input  logic                  cmp_out_c
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t           state, state_d;
  logic [IW-1:0]    win_idx, win_d;
  logic [IW-1:0]    rr_ptr, ptr_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] a_d, b_d, rb_d;
  logic [1:0]       c_d;
  logic             en_d, rc_d, busy_d;
  logic [NREQ-1:0]  gnt_d, done_d;

  logic [NREQ-1:0]  arb_gnt_c;
  logic [IW-1:0]    arb_idx_c;
  logic             arb_any_c;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic [1:0]       op_c [NREQ];

  // Split the flat request buses into per-requester operands
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g] = req_a[g*WIDTH +: WIDTH];
    assign op_b[g] = req_b[g*WIDTH +: WIDTH];
    assign op_c[g] = req_c[g*2 +: 2];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c),
    .any_c (arb_any_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d = state;
    win_d   = win_idx;
    ptr_d   = rr_ptr;
    cnt_d   = cnt;
    a_d     = cmp_a;
    b_d     = cmp_b;
    c_d     = cmp_c;
    en_d    = cmp_en;
    gnt_d   = gnt;
    done_d  = '0;
    rb_d    = res_bits;
    rc_d    = res_c;
    case (state)
      ST_IDLE: begin
        if (arb_any_c) begin
          state_d = ST_ISSUE;
          win_d   = arb_idx_c;
          a_d     = op_a[arb_idx_c];
          b_d     = op_b[arb_idx_c];
          c_d     = op_c[arb_idx_c];
          gnt_d   = arb_gnt_c;
          en_d    = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CW'(LAT - 1);
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_d = ST_DONE;
          rb_d    = cmp_out_bits;
          rc_d    = cmp_out_c;
          en_d    = 1'b0;
          done_d  = gnt;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_idx  <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      cmp_a    <= '0;
      cmp_b    <= '0;
      cmp_c    <= '0;
      cmp_en   <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      res_bits <= '0;
      res_c    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      win_idx  <= win_d;
      rr_ptr   <= ptr_d;
      cnt      <= cnt_d;
      cmp_a    <= a_d;
      cmp_b    <= b_d;
      cmp_c    <= c_d;
      cmp_en   <= en_d;
      gnt      <= gnt_d;
      done     <= done_d;
      res_bits <= rb_d;
      res_c    <= rc_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_cmp_scheduler.sv
// Bench for cmp_scheduler: stub comparator, timeline model checked every cycle, directed literals.
module tb_cmp_scheduler;
  import cmp_sched_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned LAT   = 1;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req   = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ*2-1:0]     req_c = '0;
  logic [NREQ-1:0]       gnt, done;
  logic [WIDTH-1:0]      res_bits, cmp_a, cmp_b;
  logic                  res_c, busy, cmp_en;
  logic [1:0]            cmp_c;
  logic [WIDTH-1:0]      cmp_out_bits = '0;
  logic                  cmp_out_c    = 1'b0;

  cmp_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_c        (req_c),
    .gnt          (gnt),
    .done         (done),
    .res_bits     (res_bits),
    .res_c        (res_c),
    .busy         (busy),
    .cmp_a        (cmp_a),
    .cmp_b        (cmp_b),
    .cmp_c        (cmp_c),
    .cmp_en       (cmp_en),
    .cmp_out_bits (cmp_out_bits),
    .cmp_out_c    (cmp_out_c)
  );

  always #5 clk = ~clk;

  // Stub comparator: registered xor / greater-than, holds while disabled
  always @(posedge clk) begin
    if (cmp_en) begin
      cmp_out_bits <= cmp_a ^ cmp_b;
      cmp_out_c    <= (cmp_a > cmp_b);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] sl(input logic [NREQ*WIDTH-1:0] v, input int unsigned i);
    return WIDTH'(v >> (i * WIDTH));
  endfunction

  function automatic logic [1:0] slc(input logic [NREQ*2-1:0] v, input int unsigned i);
    return 2'(v >> (i * 2));
  endfunction

  function automatic int unsigned pick(input logic [NREQ-1:0] r, input int unsigned p);
    for (int unsigned k = 0; k < NREQ; k++) begin
      if ((r & (NREQ'(1) << ((p + k) % NREQ))) != '0) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic int unsigned oh2i(input logic [NREQ-1:0] v);
    for (int unsigned k = 0; k < NREQ; k++) begin
      if ((v & (NREQ'(1) << k)) != '0) return k;
    end
    return 99;
  endfunction

  // Model: age counts cycles since grant (0 = idle); everything follows from age
  int unsigned      m_age, m_win, m_ptr;
  logic [WIDTH-1:0] m_a, m_b, m_rb;
  logic [1:0]       m_c;
  logic             m_rc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= 0; m_win <= 0; m_ptr <= 0;
      m_a <= '0; m_b <= '0; m_c <= '0; m_rb <= '0; m_rc <= 1'b0;
    end else if (m_age == 0) begin
      if (req != '0) begin
        m_win <= pick(req, m_ptr);
        m_a   <= sl(req_a, pick(req, m_ptr));
        m_b   <= sl(req_b, pick(req, m_ptr));
        m_c   <= slc(req_c, pick(req, m_ptr));
        m_age <= 1;
      end
    end else if (m_age == 2 + LAT) begin
      m_age <= 0;
      m_ptr <= (m_win + 1) % NREQ;
    end else begin
      if (m_age == 1 + LAT) begin
        m_rb <= m_a ^ m_b;
        m_rc <= (m_a > m_b);
      end
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("gnt",      32'(gnt),      (m_age != 0) ? 32'(NREQ'(1) << m_win) : 32'd0);
      chk("done",     32'(done),     (m_age == 2 + LAT) ? 32'(NREQ'(1) << m_win) : 32'd0);
      chk("busy",     32'(busy),     32'(m_age != 0));
      chk("cmp_en",   32'(cmp_en),   32'(m_age >= 1 && m_age <= 1 + LAT));
      chk("cmp_a",    32'(cmp_a),    32'(m_a));
      chk("cmp_b",    32'(cmp_b),    32'(m_b));
      chk("cmp_c",    32'(cmp_c),    32'(m_c));
      chk("res_bits", 32'(res_bits), 32'(m_rb));
      chk("res_c",    32'(res_c),    32'(m_rc));
    end
  end

  // Requester-side helpers and a log of DONE pulses
  int unsigned     cyc = 0;
  int unsigned     n_log = 0;
  int unsigned     log_idx [16];
  int unsigned     log_cyc [16];
  bit              auto_drop = 1'b1;
  bit              rearm = 1'b0;
  logic [NREQ-1:0] pend = '0;

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (rearm) begin
      req  = req | pend;
      pend = '0;
    end
    if (done != '0) begin
      if (n_log < 16) begin
        log_idx[n_log] = oh2i(done);
        log_cyc[n_log] = cyc;
      end
      n_log++;
      if (auto_drop) begin
        req  = req & ~done;
        pend = done;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    pend  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    n_log = 0;
  endtask

  initial begin
    do_reset();
    chk_on = 1'b1;

    // Reset state literals
    chk("rst_gnt",  32'(gnt),    32'h0);
    chk("rst_busy", 32'(busy),   32'h0);
    chk("rst_en",   32'(cmp_en), 32'h0);

    // Single op from requester 0: 3 ^ 2 = 1, 3 > 2
    req_a[0 +: WIDTH] = 4'b0011;
    req_b[0 +: WIDTH] = 4'b0010;
    req_c[0 +: 2]     = MODE_0;
    req = 4'b0001;
    tick();
    chk("t1_gnt_c1", 32'(gnt),    32'h1);
    chk("t1_en_c1",  32'(cmp_en), 32'h1);
    chk("t1_a_c1",   32'(cmp_a),  32'h3);
    tick();
    chk("t1_en_c2",   32'(cmp_en), 32'h1);
    chk("t1_done_c2", 32'(done),   32'h0);
    tick();
    chk("t1_done_c3", 32'(done),     32'h1);
    chk("t1_res",     32'(res_bits), 32'h1);
    chk("t1_resc",    32'(res_c),    32'h1);
    chk("t1_en_c3",   32'(cmp_en),   32'h0);
    tick();
    chk("t1_done_c4", 32'(done), 32'h0);
    chk("t1_busy_c4", 32'(busy), 32'h0);

    // All four requesting continuously; pointer restarts at 0 after reset
    do_reset();
    req_a = 16'h4321;
    req_b = 16'h1234;
    req_c = {MODE_3, MODE_2, MODE_1, MODE_0};
    rearm = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 20; i++) tick();
    rearm = 1'b0;
    chk("t2_ndone", n_log, 32'd5);
    for (int unsigned i = 0; i < 5; i++) begin
      if (i < n_log) begin
        chk("t2_order", log_idx[i], i % NREQ);
        if (i > 0) chk("t2_gap", log_cyc[i] - log_cyc[i-1], 32'd4);
      end else begin
        chk("t2_missing_done", 32'd0, 32'd1);
      end
    end

    // Operand change after grant is ignored
    do_reset();
    req_a[2*WIDTH +: WIDTH] = 4'b0111;
    req_b[2*WIDTH +: WIDTH] = 4'b0111;
    req_c[4 +: 2]           = MODE_2;
    req = 4'b0100;
    tick();
    tick();
    req_a[2*WIDTH +: WIDTH] = 4'b1111;
    chk("t3_a_wait", 32'(cmp_a), 32'h7);
    tick();
    chk("t3_a_done", 32'(cmp_a),    32'h7);
    chk("t3_c",      32'(cmp_c),    32'h2);
    chk("t3_done",   32'(done),     32'h4);
    chk("t3_res",    32'(res_bits), 32'h0);
    chk("t3_resc",   32'(res_c),    32'h0);

    // Reset during WAIT discards the op
    do_reset();
    req_a[0 +: WIDTH] = 4'b1010;
    req_b[0 +: WIDTH] = 4'b0101;
    req_c[0 +: 2]     = MODE_1;
    req = 4'b0001;
    tick(); tick(); tick();
    chk("t4_res_first", 32'(res_bits), 32'hf);
    req = '0;
    tick();
    req_a[2*WIDTH +: WIDTH] = 4'b0110;
    req_b[2*WIDTH +: WIDTH] = 4'b0001;
    req_c[4 +: 2]           = MODE_3;
    req = 4'b0100;
    tick();
    chk("t4_gnt_issue", 32'(gnt), 32'h4);
    tick();
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("t4_rst_gnt",  32'(gnt),      32'h0);
    chk("t4_rst_en",   32'(cmp_en),   32'h0);
    chk("t4_rst_busy", 32'(busy),     32'h0);
    chk("t4_rst_res",  32'(res_bits), 32'h0);
    chk("t4_rst_a",    32'(cmp_a),    32'h0);
    tick(); tick();
    rst_n = 1'b1;
    chk("t4_no_done", n_log, 32'd1);
    req = 4'b0100;
    tick();
    chk("t4_regrant", 32'(gnt), 32'h4);
    tick(); tick();
    chk("t4_done",  32'(done),     32'h4);
    chk("t4_res",   32'(res_bits), 32'h7);
    chk("t4_resc",  32'(res_c),    32'h1);

    // Requester drops REQ mid-op; DONE still pulses, pointer moves to 2
    do_reset();
    req_a[1*WIDTH +: WIDTH] = 4'b1100;
    req_b[1*WIDTH +: WIDTH] = 4'b0101;
    req_c[2 +: 2]           = MODE_1;
    req = 4'b0010;
    tick(); tick();
    req = '0;
    tick();
    chk("t5_done", 32'(done),     32'h2);
    chk("t5_res",  32'(res_bits), 32'h9);
    chk("t5_resc", 32'(res_c),    32'h1);
    tick();
    req = 4'b0111;
    tick();
    chk("t5_ptr2", 32'(gnt), 32'h4);

    // Simultaneous 3 and 0 with pointer at 3
    do_reset();
    req = 4'b0100;
    tick(); tick(); tick(); tick();
    req_a[3*WIDTH +: WIDTH] = 4'b1001;
    req_b[3*WIDTH +: WIDTH] = 4'b1001;
    req_a[0 +: WIDTH]       = 4'b0001;
    req_b[0 +: WIDTH]       = 4'b1000;
    n_log = 0;
    req   = 4'b1001;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_ndone", n_log, 32'd2);
    if (n_log >= 2) begin
      chk("t6_first",  log_idx[0], 32'd3);
      chk("t6_second", log_idx[1], 32'd0);
      chk("t6_gap",    log_cyc[1] - log_cyc[0], 32'd4);
    end else begin
      chk("t6_missing_done", n_log, 32'd2);
    end
    chk("t6_res", 32'(res_bits), 32'h9);

    tick();
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
